// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
// Multi-channel programmable clock divider running entirely on the PLL core
// clock. Each channel produces a registered divided square wave (clk_div) and
// a one-cycle clock enable (tick) on the last cycle of every period, at ratio
// R = div+1. New divisors are staged in a shadow register and take effect only
// at the channel's period boundary, so the divided clock never emits a runt.
//
// Optional feature macro: CLK_DIV_SYNC_EN
//   defined   : sync_i port present; holding it high forces every enabled
//               channel to phase 0 and applies pending divisors.
//   undefined : sync_i absent; channel phase follows ch_en only.
//
// Ports
//   clk        PLL core clock, sole clock of the block
//   reset      synchronous active-high reset (priority over all inputs)
//   sync_i     phase realign (CLK_DIV_SYNC_EN builds only)
//   ch_en      per-channel run enable
//   div_wr     per-channel divisor write strobe
//   div_wdata  divisor written to every channel whose div_wr is high
//   div_pend   per-channel: written divisor not yet applied
//   clk_div    per-channel divided square wave, high for ceil(R/2) of R cycles
//   tick       per-channel one-cycle pulse on the last cycle of each period
// ---------------------------------------------------------------------------
module clk_div_bank #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DIV_WIDTH = 8,
   parameter int unsigned DIV_RESET = 1
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef CLK_DIV_SYNC_EN
   input  logic                 sync_i,
`endif
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic [NUM_CH-1:0]    div_wr,
   input  logic [DIV_WIDTH-1:0] div_wdata,
   output logic [NUM_CH-1:0]    div_pend,
   output logic [NUM_CH-1:0]    clk_div,
   output logic [NUM_CH-1:0]    tick
);

   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

   // Per-channel state: active divisor, shadow divisor, phase counter.
   logic [NUM_CH-1:0][DIV_WIDTH-1:0] act_q, act_d;
   logic [NUM_CH-1:0][DIV_WIDTH-1:0] shd_q, shd_d;
   logic [NUM_CH-1:0][DIV_WIDTH-1:0] ph_q,  ph_d;
   logic [NUM_CH-1:0]                pend_q, pend_d;
   logic [NUM_CH-1:0]                run_q, run_d;
   logic [NUM_CH-1:0]                clk_div_d, tick_d;
   logic [NUM_CH-1:0]                apply_c;
   logic                             sync_c;

`ifdef CLK_DIV_SYNC_EN
   assign sync_c = sync_i;
`else
   assign sync_c = 1'b0;
`endif

   // Next-state: phase advance, divisor staging/apply, registered outputs.
   always_comb begin
      act_d     = act_q;
      shd_d     = shd_q;
      ph_d      = ph_q;
      pend_d    = pend_q;
      run_d     = ch_en;
      clk_div_d = '0;
      tick_d    = '0;
      apply_c   = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (!ch_en[i]) begin
            // Idle: phase frozen, a pending divisor can be applied safely.
            apply_c[i] = pend_q[i];
         end else if (sync_c || !run_q[i]) begin
            // Start of run or forced realign: begin a fresh period at phase 0.
            ph_d[i]    = '0;
            apply_c[i] = pend_q[i];
         end else if (ph_q[i] == act_q[i]) begin
            // Wrap: the next period starts here and picks up any staged divisor.
            ph_d[i]    = '0;
            apply_c[i] = pend_q[i];
         end else begin
            ph_d[i] = ph_q[i] + DIV_WIDTH'(1);
         end

         if (apply_c[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
         end

         // A write on the same edge lands in the shadow after any apply above.
         if (div_wr[i]) begin
            shd_d[i]  = div_wdata;
            pend_d[i] = 1'b1;
         end

         if (ch_en[i]) begin
            clk_div_d[i] = (ph_d[i] <= (act_d[i] >> 1));
            tick_d[i]    = (ph_d[i] == act_d[i]);
         end
      end
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            act_q[i] <= DIV_RST;
            shd_q[i] <= DIV_RST;
            ph_q[i]  <= '0;
         end
         pend_q  <= '0;
         run_q   <= '0;
         clk_div <= '0;
         tick    <= '0;
      end else begin
         act_q   <= act_d;
         shd_q   <= shd_d;
         ph_q    <= ph_d;
         pend_q  <= pend_d;
         run_q   <= run_d;
         clk_div <= clk_div_d;
         tick    <= tick_d;
      end
   end

   assign div_pend = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_div_bank
// Directed, table-driven bench for clk_div_bank (NUM_CH=4, DIV_WIDTH=8).
// Each table row is one clock edge: inputs applied before the edge, expected
// registered outputs checked 1 ns after it. Hand-written sequences cover the
// odd ratio, R=1, R=256 and (when CLK_DIV_SYNC_EN is defined) realignment.
// ---------------------------------------------------------------------------
module tb_clk_div_bank;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sync_i = 1'b0;
   logic [3:0] ch_en = '0;
   logic [3:0] div_wr = '0;
   logic [7:0] div_wdata = '0;
   logic [3:0] div_pend;
   logic [3:0] clk_div;
   logic [3:0] tick;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       rst;
      logic [3:0] en;
      logic [3:0] wr;
      logic [7:0] wd;
      logic [3:0] ck;
      logic [3:0] tk;
      logic [3:0] pd;
   } vec_t;

   vec_t vecs[$];

   clk_div_bank #(.NUM_CH(4), .DIV_WIDTH(8), .DIV_RESET(1)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef CLK_DIV_SYNC_EN
      .sync_i    (sync_i),
`endif
      .ch_en     (ch_en),
      .div_wr    (div_wr),
      .div_wdata (div_wdata),
      .div_pend  (div_pend),
      .clk_div   (clk_div),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive inputs, take one edge, settle 1 ns past it.
   task automatic edge_step(input logic rst, input logic [3:0] en,
                            input logic [3:0] wr, input logic [7:0] wd);
      reset     = rst;
      ch_en     = en;
      div_wr    = wr;
      div_wdata = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rst, input logic [3:0] en, input logic [3:0] wr,
                      input logic [7:0] wd, input logic [3:0] ck,
                      input logic [3:0] tk, input logic [3:0] pd);
      vec_t v;
      v.rst = rst; v.en = en; v.wr = wr; v.wd = wd;
      v.ck = ck; v.tk = tk; v.pd = pd;
      vecs.push_back(v);
   endtask

   initial begin
      int first_t;
      int second_t;
      int p;

      // rst en wr wd | clk_div tick div_pend
      add(1, 4'b0000, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0000); // 0 reset
      add(1, 4'b0000, 4'b1111, 8'd5, 4'b0000, 4'b0000, 4'b0000); // 1 reset beats write
      add(0, 4'b0000, 4'b0001, 8'd3, 4'b0000, 4'b0000, 4'b0001); // 2 stage div=3
      add(0, 4'b0000, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0000); // 3 applied while idle
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0011, 4'b0000, 4'b0000); // 4 enable: p=0
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0001, 4'b0010, 4'b0000); // 5
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0010, 4'b0000, 4'b0000); // 6
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0000, 4'b0011, 4'b0000); // 7 ch0 tick p=3
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0011, 4'b0000, 4'b0000); // 8 wrap
      add(0, 4'b0011, 4'b0001, 8'd1, 4'b0001, 4'b0010, 4'b0001); // 9 write div=1 mid
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0010, 4'b0000, 4'b0001); // 10
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0000, 4'b0011, 4'b0001); // 11 old period ends
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0011, 4'b0000, 4'b0000); // 12 wrap applies R=2
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0000, 4'b0011, 4'b0000); // 13
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0011, 4'b0000, 4'b0000); // 14
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0000, 4'b0011, 4'b0000); // 15
      add(0, 4'b0011, 4'b0001, 8'd3, 4'b0011, 4'b0000, 4'b0001); // 16 write on wrap
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0000, 4'b0011, 4'b0001); // 17 one more R=2
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0011, 4'b0000, 4'b0000); // 18 R=4 applied
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0001, 4'b0010, 4'b0000); // 19
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0010, 4'b0000, 4'b0000); // 20 ch0 p=2
      add(0, 4'b0010, 4'b0000, 8'd0, 4'b0000, 4'b0010, 4'b0000); // 21 drop ch0
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0011, 4'b0000, 4'b0000); // 22 restart p=0
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0001, 4'b0010, 4'b0000); // 23
      add(0, 4'b0011, 4'b0000, 8'd0, 4'b0010, 4'b0000, 4'b0000); // 24
      add(0, 4'b0011, 4'b0001, 8'd7, 4'b0000, 4'b0011, 4'b0001); // 25 pend set
      add(1, 4'b0011, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0000); // 26 reset clears
      add(0, 4'b0001, 4'b0000, 8'd0, 4'b0001, 4'b0000, 4'b0000); // 27 A=DIV_RESET
      add(0, 4'b0001, 4'b0000, 8'd0, 4'b0000, 4'b0001, 4'b0000); // 28 R=2 confirmed

      #2;
      foreach (vecs[i]) begin
         edge_step(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].wd);
         chk($sformatf("row%0d_clk_div", i), 32'(clk_div), 32'(vecs[i].ck));
         chk($sformatf("row%0d_tick", i), 32'(tick), 32'(vecs[i].tk));
         chk($sformatf("row%0d_div_pend", i), 32'(div_pend), 32'(vecs[i].pd));
      end

      // Odd ratio div=4 on ch2: high 3, low 2, tick at p=4.
      edge_step(1, 4'b0000, 4'b0000, 8'd0);
      edge_step(0, 4'b0000, 4'b0100, 8'd4);
      edge_step(0, 4'b0000, 4'b1000, 8'd0);
      edge_step(0, 4'b0000, 4'b0000, 8'd0);
      chk("odd_pend_cleared", 32'(div_pend), 32'd0);
      for (int j = 0; j < 10; j++) begin
         edge_step(0, 4'b1100, 4'b0000, 8'd0);
         p = j % 5;
         chk($sformatf("r5_clk_j%0d", j), 32'(clk_div[2]), 32'(p <= 2));
         chk($sformatf("r5_tick_j%0d", j), 32'(tick[2]), 32'(p == 4));
         // ch3 runs at R=1 alongside: constant high, tick every cycle.
         chk($sformatf("r1_clk_j%0d", j), 32'(clk_div[3]), 32'd1);
         chk($sformatf("r1_tick_j%0d", j), 32'(tick[3]), 32'd1);
      end

      // Limit ratio div=255 on ch2: first tick 255 edges after enable, period 256.
      edge_step(0, 4'b0000, 4'b0100, 8'd255);
      edge_step(0, 4'b0000, 4'b0000, 8'd0);
      first_t = -1;
      second_t = -1;
      for (int j = 0; j < 600 && second_t < 0; j++) begin
         edge_step(0, 4'b0100, 4'b0000, 8'd0);
         if (j == 0) chk("r256_start_clk", 32'(clk_div[2]), 32'd1);
         if (j == 128) chk("r256_mid_clk_low", 32'(clk_div[2]), 32'd0);
         if (tick[2] === 1'b1) begin
            if (first_t < 0) first_t = j;
            else second_t = j;
         end
      end
      chk("r256_first_tick", 32'(first_t), 32'd255);
      chk("r256_period", 32'(second_t - first_t), 32'd256);

`ifdef CLK_DIV_SYNC_EN
      // Two R=4 channels started a cycle apart, realigned by a one-cycle sync.
      edge_step(1, 4'b0000, 4'b0000, 8'd0);
      edge_step(0, 4'b0000, 4'b0011, 8'd3);
      edge_step(0, 4'b0000, 4'b0000, 8'd0);
      edge_step(0, 4'b0001, 4'b0000, 8'd0);
      edge_step(0, 4'b0011, 4'b0000, 8'd0);
      sync_i = 1'b1;
      edge_step(0, 4'b0011, 4'b0000, 8'd0);
      sync_i = 1'b0;
      chk("sync_clk", 32'(clk_div[1:0]), 32'h3);
      chk("sync_tick", 32'(tick[1:0]), 32'h0);
      for (int j = 1; j <= 8; j++) begin
         edge_step(0, 4'b0011, 4'b0000, 8'd0);
         chk($sformatf("sync_tick0_j%0d", j), 32'(tick[0]), 32'((j % 4) == 3));
         chk($sformatf("sync_tick1_j%0d", j), 32'(tick[1]), 32'((j % 4) == 3));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
